// File: rtl/n_bit_seq_subtractor.sv
// Multi-cycle borrow-ripple subtractor: d = a - b - bin, W bits per clock, LSB chunk first.
// Operands are captured on the input handshake; the result is held until the consumer takes it.
module n_bit_seq_subtractor #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);
    localparam int CHUNKS = N / W;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   a_r, b_r;
    logic           borrow;
    logic [CW-1:0]  cnt;
    logic [31:0]    base;
    logic [W-1:0]   a_chunk, b_chunk;
    logic [W:0]     diff;
    logic [N-1:0]   d_nxt;
    logic           last;

    // One chunk of the ripple; the extra top bit of diff is the outgoing borrow.
    always_comb begin
        base    = 32'(cnt) * 32'(W);
        a_chunk = a_r[base +: W];
        b_chunk = b_r[base +: W];
        diff    = {1'b0, a_chunk} - {1'b0, b_chunk} - (W+1)'(borrow);
        d_nxt   = d;
        d_nxt[base +: W] = diff[W-1:0];
        last    = (cnt == CW'(CHUNKS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r    <= a;
                    b_r    <= b;
                    borrow <= bin;
                    d      <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    borrow <= diff[W];
                    d      <= d_nxt;
                    cnt    <= cnt + 1'b1;
                    // Flags come from the fully assembled difference on the final chunk.
                    if (last) begin
                        bout <= diff[W];
                        ovf  <= (a_r[N-1] != b_r[N-1]) & (d_nxt[N-1] != a_r[N-1]);
                        zero <= (d_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_n_bit_seq_subtractor.sv
// Directed bench for n_bit_seq_subtractor (N=8, W=2) with hand-computed expected results.
module tb_n_bit_seq_subtractor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] a, b;
    logic       bin;
    logic       out_valid, out_ready;
    logic [7:0] d;
    logic       bout, ovf, zero;

    int n_checks = 0;
    int n_pass   = 0;

    n_bit_seq_subtractor #(.N(8), .W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Present operands and complete the input handshake; returns #1 after the accept edge.
    task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = ia; b = ib; bin = ibin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 20);
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [7:0] ed, input logic eb,
                             input logic eo, input logic ez);
        check({tag, "_d"},    32'(d),    32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_ovf"},  32'(ovf),  32'(eo));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] ed, input logic eb,
                          input logic eo, input logic ez);
        int lat;
        start_op(ia, ib, ibin);
        wait_result(lat);
        check_res(tag, ed, eb, eo, ez);
        finish_op(tag);
    endtask

    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vbin [3];
    logic [7:0] vd [3];
    logic       vbo [3];
    logic       vov [3];

    initial begin
        int lat, acc_idx, res_idx, last_acc, cyc;
        logic rdy;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic op with latency check
        start_op(8'h50, 8'h20, 1'b0);
        wait_result(lat);
        check("latency", 32'(lat), 32'd4);
        check_res("basic", 8'h30, 1'b0, 1'b0, 1'b0);
        finish_op("basic");

        run_op("under",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("ovf",     8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("zero",    8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("bin_wrap", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Backpressure: result must hold and new operands be ignored
        start_op(8'h3C, 8'h5A, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin a = 8'h11; b = 8'h22; bin = 1'b1; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check_res("bp", 8'hE2, 1'b1, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        finish_op("bp");
        repeat (6) begin @(posedge clk); #1; end
        check("bp_no_ghost", 32'(out_valid), 32'd0);
        check("bp_hold_d",   32'(d),         32'hE2);

        // Reset in the middle of RUN aborts the operation
        start_op(8'h77, 8'h11, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_d",         32'(d),         32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid2", 32'(out_valid), 32'd0);
        run_op("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        va[0] = 8'h9A; vb[0] = 8'h3B; vbin[0] = 1'b0; vd[0] = 8'h5F; vbo[0] = 1'b0; vov[0] = 1'b1;
        va[1] = 8'h01; vb[1] = 8'h02; vbin[1] = 1'b1; vd[1] = 8'hFE; vbo[1] = 1'b1; vov[1] = 1'b0;
        va[2] = 8'h7F; vb[2] = 8'h80; vbin[2] = 1'b0; vd[2] = 8'hFF; vbo[2] = 1'b1; vov[2] = 1'b1;
        acc_idx = 0; res_idx = 0; last_acc = -1;
        a = va[0]; b = vb[0]; bin = vbin[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (cyc = 0; cyc < 60 && res_idx < 3; cyc++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy && in_valid) begin
                if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                acc_idx++;
                if (acc_idx < 3) begin a = va[acc_idx]; b = vb[acc_idx]; bin = vbin[acc_idx]; end
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                check("b2b_d",    32'(d),    32'(vd[res_idx]));
                check("b2b_bout", 32'(bout), 32'(vbo[res_idx]));
                check("b2b_ovf",  32'(ovf),  32'(vov[res_idx]));
                res_idx++;
            end
        end
        check("b2b_results", 32'(res_idx), 32'd3);
        in_valid = 1'b0; out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/n_bit_seq_subtractor.md
Name: n_bit_seq_subtractor

Overview:
- Multi-cycle borrow-ripple subtractor: computes d = a - b - bin, the inverse operation of the team's combinational carry adders.
- Processes W bits per clock, LSB chunk first, propagating borrow between chunks.
- Valid/ready handshakes on input and output; sits in datapath units where area matters more than latency.

Parameters:
- N, 8, operand/result width in bits.
- W, 2, bits processed per cycle; N must be an integer multiple of W; W=N gives single-pass operation.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend, unsigned or two's complement.
- b  input  N  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- d  output  N  difference, mod 2^N.
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  d == 0.

Behaviour:
- Reset is asynchronous on rst_n low.
  - State goes to IDLE; chunk counter = 0.
  - in_ready = 1 after reset releases.
  - out_valid, d, bout, ovf and zero all = 0.
  - Reset asserted mid-operation aborts that operation; no result is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, register a, b and bin (as borrow), clear d, clear counter, go to RUN. Otherwise stay in IDLE.
  - RUN: in_ready = 0. Each cycle, chunk k = counter computes {borrow', d[kW+W-1:kW]} = a_chunk - b_chunk - borrow.
    - Borrow register updates with the result.
    - Counter increments.
    - After chunk N/W-1 is written: go to DONE, set out_valid = 1, set bout = final borrow, compute ovf and zero from the full d.
  - DONE: in_ready = 0; out_valid = 1. Outputs stay stable while out_ready = 0. On out_ready = 1: out_valid drops, go to IDLE.
- No new operand is accepted in the same cycle as DONE -> IDLE.
- Throughput: one operation per N/W + 2 cycles.
- Latency: operands accepted at edge E0; out_valid is high after edge E(N/W).
- Input changes on a/b/bin while in RUN/DONE have no effect; operands are registered.
- in_valid outside IDLE is ignored and not queued.
- ovf = (a[N-1] != b[N-1]) & (d[N-1] != a[N-1]), using the registered operands. bin does not enter the ovf term beyond its effect on d.
- d, bout, ovf and zero hold their last values after the output handshake until the next result is loaded. Consumers sample them only when out_valid = 1.
- Counter width = clog2(N/W), minimum 1 bit. For W = N, RUN lasts exactly one cycle.

Test Plan:
- N=8, W=2: a=0x50, b=0x20, bin=0 -> d=0x30, bout=0, ovf=0, zero=0; out_valid high exactly 4 cycles after the accept edge.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0; then a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1.
- a=0x05, b=0x04, bin=1 -> d=0x00, zero=1, bout=0; then a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1, zero=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with new operands meanwhile -> d/flags stable, in_ready=0, new operands ignored; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Assert rst_n=0 two cycles into RUN -> out_valid=0, d=0, in_ready=1 after release; next op a=0x10, b=0x01 -> d=0x0F, bout=0.
- Back-to-back: in_valid and out_ready held at 1 for 3 ops -> each result correct; accepts spaced N/W+2 = 6 cycles apart.
